env_step_sched: RTL and testbench

ENV_STEP_SCHED -- requirements
Module: env_step_sched

---
 rtl/env_step_sched_if.sv | 48 ++++
 rtl/env_step_sched.sv | 139 +++++++++++++
 tb/tb_env_step_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/env_step_sched_if.sv
// Handshake and datapath bundle for the lockstep environment step scheduler.
interface env_step_sched_if #(
  parameter int unsigned PE_NUM = 20,
  parameter int unsigned STA_WL = 128,
  parameter int unsigned ACT_WL = 1,
  parameter int unsigned RWD_WL = 1,
  parameter int unsigned CNT_WL = 16
);
  logic                       i_init_valid;
  logic [PE_NUM*STA_WL-1:0]   i_init_sta;
  logic                       o_init_ready;
  logic                       i_act_valid;
  logic [PE_NUM*ACT_WL-1:0]   i_act;
  logic                       o_act_ready;
  logic                       o_cmpt_ena;
  logic [PE_NUM*STA_WL-1:0]   o_cmpt_sta;
  logic [PE_NUM*ACT_WL-1:0]   o_cmpt_act;
  logic [PE_NUM*STA_WL-1:0]   i_cmpt_sta;
  logic [PE_NUM*RWD_WL-1:0]   i_cmpt_rwd;
  logic [PE_NUM-1:0]          i_cmpt_done;
  logic                       i_cmpt_valid;
  logic                       o_obs_valid;
  logic [PE_NUM*STA_WL-1:0]   o_obs_sta;
  logic [PE_NUM*RWD_WL-1:0]   o_obs_rwd;
  logic [PE_NUM-1:0]          o_obs_done;
  logic                       o_obs_trunc;
  logic                       i_obs_ready;
  logic [CNT_WL-1:0]          o_step_cnt;
  logic                       o_err;

  // The scheduler side.
  modport slave (
    input  i_init_valid, i_init_sta, i_act_valid, i_act,
           i_cmpt_sta, i_cmpt_rwd, i_cmpt_done, i_cmpt_valid, i_obs_ready,
    output o_init_ready, o_act_ready, o_cmpt_ena, o_cmpt_sta, o_cmpt_act,
           o_obs_valid, o_obs_sta, o_obs_rwd, o_obs_done, o_obs_trunc,
           o_step_cnt, o_err
  );

  // The agent / datapath side.
  modport master (
    output i_init_valid, i_init_sta, i_act_valid, i_act,
           i_cmpt_sta, i_cmpt_rwd, i_cmpt_done, i_cmpt_valid, i_obs_ready,
    input  o_init_ready, o_act_ready, o_cmpt_ena, o_cmpt_sta, o_cmpt_act,
           o_obs_valid, o_obs_sta, o_obs_rwd, o_obs_done, o_obs_trunc,
           o_step_cnt, o_err
  );
endinterface

// File: rtl/env_step_sched.sv
// Episode scheduler: init -> (observe -> act -> compute -> commit)* with sticky
// per-environment termination, step truncation and a datapath watchdog.
module env_step_sched #(
  parameter int unsigned PE_NUM   = 20,
  parameter int unsigned STA_WL   = 128,
  parameter int unsigned ACT_WL   = 1,
  parameter int unsigned RWD_WL   = 1,
  parameter int unsigned MAX_STEP = 500,
  parameter int unsigned CNT_WL   = 16,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  env_step_sched_if.slave   bus
);
  localparam int unsigned TMO_WL = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WL-1:0] MAX_CNT = CNT_WL'(MAX_STEP);

  typedef enum logic [2:0] {S_IDLE, S_OBS, S_ACT, S_RUN, S_WAIT, S_COMMIT} state_e;

  state_e                    state_q;
  logic [PE_NUM*STA_WL-1:0]  sta_q, sta_d;
  logic [PE_NUM*ACT_WL-1:0]  act_q;
  logic [PE_NUM*RWD_WL-1:0]  rwd_q, rwd_d;
  logic [PE_NUM-1:0]         done_q, done_d;
  logic [CNT_WL-1:0]         cnt_q, cnt_d;
  logic [TMO_WL-1:0]         tmo_q, tmo_d;
  logic                      err_q, ena_q, obs_valid_q, act_ready_q, init_ready_q, trunc_q;

  // Commit values: live environments take the datapath result, finished ones freeze.
  always_comb begin
    sta_d  = sta_q;
    rwd_d  = '0;
    done_d = done_q;
    for (int unsigned k = 0; k < PE_NUM; k++) begin
      if (!done_q[k]) begin
        sta_d[k*STA_WL +: STA_WL] = bus.i_cmpt_sta[k*STA_WL +: STA_WL];
        rwd_d[k*RWD_WL +: RWD_WL] = bus.i_cmpt_rwd[k*RWD_WL +: RWD_WL];
        done_d[k]                 = bus.i_cmpt_done[k];
      end
    end
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WL'(1);
    tmo_d = tmo_q + TMO_WL'(1);
  end

  // Handshake flags are registered alongside the state they decode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      sta_q        <= '0;
      act_q        <= '0;
      rwd_q        <= '0;
      done_q       <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      ena_q        <= 1'b0;
      obs_valid_q  <= 1'b0;
      act_ready_q  <= 1'b0;
      init_ready_q <= 1'b1;
      trunc_q      <= 1'b0;
    end else begin
      ena_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (bus.i_init_valid) begin
          sta_q        <= bus.i_init_sta;
          done_q       <= '0;
          rwd_q        <= '0;
          cnt_q        <= '0;
          err_q        <= 1'b0;
          trunc_q      <= (MAX_CNT == CNT_WL'(0));
          init_ready_q <= 1'b0;
          obs_valid_q  <= 1'b1;
          state_q      <= S_OBS;
        end
        S_OBS: if (bus.i_obs_ready) begin
          obs_valid_q <= 1'b0;
          if ((&done_q) || trunc_q) begin
            init_ready_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            act_ready_q <= 1'b1;
            state_q     <= S_ACT;
          end
        end
        S_ACT: if (bus.i_act_valid) begin
          act_q       <= bus.i_act;
          act_ready_q <= 1'b0;
          ena_q       <= 1'b1;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_cmpt_valid) begin
            state_q <= S_COMMIT;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == TMO_WL'(TIMEOUT)) begin
              err_q        <= 1'b1;
              init_ready_q <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
        S_COMMIT: begin
          sta_q       <= sta_d;
          rwd_q       <= rwd_d;
          done_q      <= done_d;
          cnt_q       <= cnt_d;
          trunc_q     <= (cnt_d >= MAX_CNT);
          obs_valid_q <= 1'b1;
          state_q     <= S_OBS;
        end
        default: begin
          obs_valid_q  <= 1'b0;
          act_ready_q  <= 1'b0;
          init_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_init_ready = init_ready_q;
  assign bus.o_act_ready  = act_ready_q;
  assign bus.o_cmpt_ena   = ena_q;
  assign bus.o_cmpt_sta   = sta_q;
  assign bus.o_cmpt_act   = act_q;
  assign bus.o_obs_valid  = obs_valid_q;
  assign bus.o_obs_sta    = sta_q;
  assign bus.o_obs_rwd    = rwd_q;
  assign bus.o_obs_done   = done_q;
  assign bus.o_obs_trunc  = trunc_q;
  assign bus.o_step_cnt   = cnt_q;
  assign bus.o_err        = err_q;
endmodule

// File: tb/tb_env_step_sched.sv
// Directed and randomised episodes for env_step_sched, checked against a per-environment array model.
module tb_env_step_sched;
  localparam int unsigned PE = 8, SW = 16, AW = 1, RW = 1, MS = 3, CW = 16, TO = 8;
  localparam int unsigned OBS_W = PE*SW + PE*RW + PE + CW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  env_step_sched_if #(.PE_NUM(PE), .STA_WL(SW), .ACT_WL(AW), .RWD_WL(RW), .CNT_WL(CW)) bus ();
  env_step_sched #(.PE_NUM(PE), .STA_WL(SW), .ACT_WL(AW), .RWD_WL(RW), .MAX_STEP(MS),
                   .CNT_WL(CW), .TIMEOUT(TO)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // Reference model: one entry per environment.
  logic [SW-1:0] m_sta [PE];
  bit            m_rwd [PE];
  bit            m_done[PE];
  int unsigned   m_step;
  int            vectors = 0;
  int            miscompares = 0;

  wire [OBS_W-1:0] obs_vec = {bus.o_obs_sta, bus.o_obs_rwd, bus.o_obs_done, bus.o_step_cnt, bus.o_obs_trunc};
  wire [5:0] hs_vec = {bus.o_init_ready, bus.o_act_ready, bus.o_obs_valid, bus.o_cmpt_ena,
                       bus.o_obs_trunc, bus.o_err};

  task automatic model_set(input logic [PE*SW-1:0] s0);
    for (int k = 0; k < PE; k++) begin
      m_sta[k] = s0[k*SW +: SW]; m_rwd[k] = 1'b0; m_done[k] = 1'b0;
    end
    m_step = 0;
  endtask

  task automatic model_commit(input logic [PE*SW-1:0] ns, input logic [PE-1:0] nr, input logic [PE-1:0] nd);
    for (int k = 0; k < PE; k++) begin
      if (m_done[k]) m_rwd[k] = 1'b0;
      else begin m_sta[k] = ns[k*SW +: SW]; m_rwd[k] = nr[k]; m_done[k] = nd[k]; end
    end
    if (m_step < (2**CW) - 1) m_step++;
  endtask

  function automatic logic [PE*SW-1:0] pack_sta();
    logic [PE*SW-1:0] s;
    for (int k = 0; k < PE; k++) s[k*SW +: SW] = m_sta[k];
    return s;
  endfunction

  function automatic logic [OBS_W-1:0] exp_obs();
    logic [PE-1:0] r, d;
    for (int k = 0; k < PE; k++) begin r[k] = m_rwd[k]; d[k] = m_done[k]; end
    return {pack_sta(), r, d, CW'(m_step), (m_step >= MS)};
  endfunction

  function automatic bit model_ends();
    bit all = 1'b1;
    for (int k = 0; k < PE; k++) all = all & m_done[k];
    return all || (m_step >= MS);
  endfunction

  function automatic logic [PE*SW-1:0] rand_sta();
    logic [PE*SW-1:0] v;
    for (int k = 0; k < PE; k++) v[k*SW +: SW] = SW'($urandom);
    return v;
  endfunction

  task automatic cyc(); @(negedge clk); endtask

  task automatic start_episode(input logic [PE*SW-1:0] s0);
    bus.i_init_sta = s0; bus.i_init_valid = 1'b1; cyc(); bus.i_init_valid = 1'b0;
    model_set(s0);
  endtask

  task automatic close_obs();
    bus.i_obs_ready = 1'b1; cyc(); bus.i_obs_ready = 1'b0;
  endtask

  // One full step from OBS back to OBS; datapath answers lat cycles after the ena pulse.
  task automatic run_step(input logic [PE*AW-1:0] act, input logic [PE*SW-1:0] ns,
                          input logic [PE-1:0] nr, input logic [PE-1:0] nd, input int lat,
                          output int act_wait, output bit ena_first, output int ena_cnt,
                          output logic [PE*SW-1:0] cap_sta, output logic [PE*AW-1:0] cap_act,
                          output bit got);
    int since;
    got = 1'b0; ena_cnt = 0; cap_sta = '0; cap_act = '0; act_wait = 0; ena_first = 1'b0; since = -1;
    close_obs();
    while (!bus.o_act_ready && act_wait < 20) begin act_wait++; cyc(); end
    if (!bus.o_act_ready) return;
    bus.i_cmpt_sta = ns; bus.i_cmpt_rwd = nr; bus.i_cmpt_done = nd;
    bus.i_act = act; bus.i_act_valid = 1'b1; cyc(); bus.i_act_valid = 1'b0;
    ena_first = bus.o_cmpt_ena;
    for (int c = 0; c < 60; c++) begin
      if (bus.o_obs_valid) begin got = 1'b1; break; end
      if (bus.o_cmpt_ena) begin ena_cnt++; cap_sta = bus.o_cmpt_sta; cap_act = bus.o_cmpt_act; since = 0; end
      else if (since >= 0) since++;
      bus.i_cmpt_valid = (since == lat);
      cyc();
    end
    bus.i_cmpt_valid = 1'b0;
    if (got) model_commit(ns, nr, nd);
  endtask

  task automatic test_reset();
    model_set('0);
    rst = 1'b1; cyc();
    vectors++; if (hs_vec !== 6'b100000) begin miscompares++; $display("FAIL reset_hs got=%b exp=%b", hs_vec, 6'b100000); end
    vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL reset_obs got=%h exp=%h", obs_vec, exp_obs()); end
    vectors++; if ({bus.o_cmpt_sta, bus.o_cmpt_act} !== '0) begin miscompares++; $display("FAIL reset_cmpt got=%h exp=0", {bus.o_cmpt_sta, bus.o_cmpt_act}); end
    rst = 1'b0; cyc();
    vectors++; if (hs_vec !== 6'b100000) begin miscompares++; $display("FAIL post_reset_hs got=%b exp=%b", hs_vec, 6'b100000); end
  endtask

  task automatic test_first_step();
    logic [PE*SW-1:0] s0, ns, cs; logic [PE*AW-1:0] ca; int aw, ec; bit ef, got;
    s0 = rand_sta(); start_episode(s0);
    vectors++; if (hs_vec !== 6'b001000) begin miscompares++; $display("FAIL first_obs_hs got=%b exp=%b", hs_vec, 6'b001000); end
    vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL first_obs got=%h exp=%h", obs_vec, exp_obs()); end
    ns = rand_sta();
    run_step('0, ns, '1, '0, 3, aw, ef, ec, cs, ca, got);
    vectors++; if (aw !== 0) begin miscompares++; $display("FAIL act_ready_latency got=%0d exp=0", aw); end
    vectors++; if (ef !== 1'b1) begin miscompares++; $display("FAIL ena_latency got=%b exp=1", ef); end
    vectors++; if (ec !== 1) begin miscompares++; $display("FAIL ena_pulses got=%0d exp=1", ec); end
    vectors++; if ({cs, ca} !== {s0, {(PE*AW){1'b0}}}) begin miscompares++; $display("FAIL cmpt_inputs got=%h exp=%h", {cs, ca}, {s0, {(PE*AW){1'b0}}}); end
    vectors++; if (!got) begin miscompares++; $display("FAIL step1_return got=0 exp=1"); end
    vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL step1_obs got=%h exp=%h", obs_vec, exp_obs()); end
    vectors++; if ({bus.o_obs_rwd, bus.o_step_cnt} !== {{PE{1'b1}}, CW'(1)}) begin miscompares++; $display("FAIL step1_rwd_cnt got=%h exp=%h", {bus.o_obs_rwd, bus.o_step_cnt}, {{PE{1'b1}}, CW'(1)}); end
  endtask

  task automatic test_done_freeze();
    logic [PE*SW-1:0] ns, cs; logic [PE*AW-1:0] ca; logic [PE-1:0] nd; logic [SW-1:0] frozen;
    int aw, ec; bit ef, got;
    nd = '0; nd[5] = 1'b1;
    run_step(PE'($urandom), rand_sta(), PE'($urandom), nd, 2, aw, ef, ec, cs, ca, got);
    vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL step2_obs got=%h exp=%h", obs_vec, exp_obs()); end
    frozen = m_sta[5];
    ns = rand_sta(); ns[5*SW +: SW] = ~frozen;
    run_step(PE'($urandom), ns, '1, '0, 4, aw, ef, ec, cs, ca, got);
    vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL step3_obs got=%h exp=%h", obs_vec, exp_obs()); end
    vectors++; if ({bus.o_obs_sta[5*SW +: SW], bus.o_obs_rwd[5], bus.o_obs_done[5]} !== {frozen, 2'b01})
      begin miscompares++; $display("FAIL env5_frozen got=%h exp=%h", {bus.o_obs_sta[5*SW +: SW], bus.o_obs_rwd[5], bus.o_obs_done[5]}, {frozen, 2'b01}); end
    close_obs();
    vectors++; if ({bus.o_init_ready, bus.o_obs_valid} !== 2'b10) begin miscompares++; $display("FAIL done_end_idle got=%b exp=10", {bus.o_init_ready, bus.o_obs_valid}); end
  endtask

  task automatic test_trunc();
    logic [PE*SW-1:0] cs; logic [PE*AW-1:0] ca; int aw, ec; bit ef, got;
    start_episode(rand_sta());
    for (int i = 1; i <= MS; i++) begin
      run_step(PE'($urandom), rand_sta(), PE'($urandom), '0, 1 + i, aw, ef, ec, cs, ca, got);
      vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL trunc_step%0d got=%h exp=%h", i, obs_vec, exp_obs()); end
    end
    vectors++; if (bus.o_obs_trunc !== 1'b1) begin miscompares++; $display("FAIL trunc_flag got=%b exp=1", bus.o_obs_trunc); end
    close_obs();
    vectors++; if ({bus.o_init_ready, bus.o_obs_valid, bus.o_act_ready} !== 3'b100) begin miscompares++; $display("FAIL trunc_end got=%b exp=100", {bus.o_init_ready, bus.o_obs_valid, bus.o_act_ready}); end
  endtask

  task automatic test_all_done();
    logic [PE*SW-1:0] cs; logic [PE*AW-1:0] ca; int aw, ec; bit ef, got;
    start_episode(rand_sta());
    run_step(PE'($urandom), rand_sta(), PE'($urandom), '1, 1, aw, ef, ec, cs, ca, got);
    vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL alldone_obs got=%h exp=%h", obs_vec, exp_obs()); end
    close_obs();
    vectors++; if ({bus.o_init_ready, bus.o_act_ready} !== 2'b10) begin miscompares++; $display("FAIL alldone_end got=%b exp=10", {bus.o_init_ready, bus.o_act_ready}); end
    start_episode(rand_sta());
    for (int i = 1; i <= MS; i++)
      run_step(PE'($urandom), rand_sta(), PE'($urandom), (i == MS) ? '1 : '0, 2, aw, ef, ec, cs, ca, got);
    vectors++; if ({bus.o_obs_done, bus.o_obs_trunc} !== {{PE{1'b1}}, 1'b1}) begin miscompares++; $display("FAIL both_flags got=%h exp=%h", {bus.o_obs_done, bus.o_obs_trunc}, {{PE{1'b1}}, 1'b1}); end
    close_obs();
    repeat (3) cyc();
    vectors++; if ({bus.o_init_ready, bus.o_act_ready, bus.o_obs_valid, bus.o_cmpt_ena} !== 4'b1000) begin miscompares++; $display("FAIL both_end_once got=%b exp=1000", {bus.o_init_ready, bus.o_act_ready, bus.o_obs_valid, bus.o_cmpt_ena}); end
  endtask

  task automatic test_timeout();
    start_episode(rand_sta());
    close_obs();
    bus.i_act = PE'($urandom); bus.i_act_valid = 1'b1; cyc(); bus.i_act_valid = 1'b0;
    vectors++; if (bus.o_cmpt_ena !== 1'b1) begin miscompares++; $display("FAIL tmo_ena got=%b exp=1", bus.o_cmpt_ena); end
    repeat (TO) cyc();
    vectors++; if ({bus.o_err, bus.o_init_ready} !== 2'b00) begin miscompares++; $display("FAIL tmo_early got=%b exp=00", {bus.o_err, bus.o_init_ready}); end
    cyc();
    vectors++; if ({bus.o_init_ready, bus.o_obs_valid, bus.o_act_ready, bus.o_err} !== 4'b1001) begin miscompares++; $display("FAIL tmo_err got=%b exp=1001", {bus.o_init_ready, bus.o_obs_valid, bus.o_act_ready, bus.o_err}); end
    bus.i_cmpt_valid = 1'b1; cyc(); bus.i_cmpt_valid = 1'b0; cyc();
    vectors++; if ({bus.o_init_ready, bus.o_obs_valid, bus.o_step_cnt} !== {2'b10, CW'(m_step)}) begin miscompares++; $display("FAIL tmo_late_valid got=%h exp=%h", {bus.o_init_ready, bus.o_obs_valid, bus.o_step_cnt}, {2'b10, CW'(m_step)}); end
    start_episode(rand_sta());
    vectors++; if (bus.o_err !== 1'b0) begin miscompares++; $display("FAIL err_clear got=%b exp=0", bus.o_err); end
  endtask

  task automatic test_obs_stall();
    int enas = 0;
    for (int i = 0; i < 10; i++) begin
      bus.i_obs_ready = 1'b0; bus.i_cmpt_valid = i[0];
      cyc();
      if (bus.o_cmpt_ena) enas++;
      vectors++; if ({obs_vec, bus.o_obs_valid} !== {exp_obs(), 1'b1}) begin miscompares++; $display("FAIL stall_c%0d got=%h exp=%h", i, {obs_vec, bus.o_obs_valid}, {exp_obs(), 1'b1}); end
    end
    bus.i_cmpt_valid = 1'b0;
    vectors++; if (enas !== 0) begin miscompares++; $display("FAIL stall_ena got=%0d exp=0", enas); end
  endtask

  task automatic test_reset_in_wait();
    close_obs();
    bus.i_cmpt_sta = rand_sta(); bus.i_cmpt_rwd = '1; bus.i_cmpt_done = '0;
    bus.i_act = PE'($urandom); bus.i_act_valid = 1'b1; cyc(); bus.i_act_valid = 1'b0;
    repeat (3) cyc();
    #2 rst = 1'b1; model_set('0);
    #1;
    vectors++; if ({hs_vec, obs_vec} !== {6'b100000, exp_obs()}) begin miscompares++; $display("FAIL async_reset got=%h exp=%h", {hs_vec, obs_vec}, {6'b100000, exp_obs()}); end
    cyc(); cyc(); rst = 1'b0;
    bus.i_cmpt_valid = 1'b1; cyc(); cyc(); bus.i_cmpt_valid = 1'b0; cyc();
    vectors++; if ({hs_vec, obs_vec, bus.o_cmpt_sta, bus.o_cmpt_act} !== {6'b100000, exp_obs(), {(PE*SW+PE*AW){1'b0}}})
      begin miscompares++; $display("FAIL reset_discard got=%h exp=%h", {hs_vec, obs_vec}, {6'b100000, exp_obs()}); end
  endtask

  task automatic test_back_to_back();
    logic [PE*SW-1:0] ns, cs, pre; logic [PE*AW-1:0] act, ca; logic [PE-1:0] nd;
    int aw, ec; bit ef, got;
    for (int ep = 0; ep < 6; ep++) begin
      start_episode(rand_sta());
      vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL b2b_ep%0d_init got=%h exp=%h", ep, obs_vec, exp_obs()); end
      while (!model_ends()) begin
        for (int k = 0; k < PE; k++) nd[k] = ($urandom_range(0, 3) == 0);
        ns = rand_sta(); act = PE'($urandom); pre = pack_sta();
        run_step(act, ns, PE'($urandom), nd, int'($urandom_range(1, 5)), aw, ef, ec, cs, ca, got);
        vectors++; if ({got, ec, cs, ca} !== {1'b1, 1, pre, act}) begin miscompares++; $display("FAIL b2b_ep%0d_cmpt got=%h exp=%h", ep, {got, ec, cs, ca}, {1'b1, 1, pre, act}); end
        vectors++; if (obs_vec !== exp_obs()) begin miscompares++; $display("FAIL b2b_ep%0d_obs got=%h exp=%h", ep, obs_vec, exp_obs()); end
        if (!got) break;
      end
      close_obs();
      vectors++; if (bus.o_init_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ep%0d_end got=%b exp=1", ep, bus.o_init_ready); end
    end
  endtask

  initial begin
    bus.i_init_valid = 1'b0; bus.i_init_sta = '0; bus.i_act_valid = 1'b0; bus.i_act = '0;
    bus.i_cmpt_sta = '0; bus.i_cmpt_rwd = '0; bus.i_cmpt_done = '0; bus.i_cmpt_valid = 1'b0;
    bus.i_obs_ready = 1'b0;
    test_reset();
    test_first_step();
    test_done_freeze();
    test_trunc();
    test_all_done();
    test_timeout();
    test_obs_stall();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
